// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared cpu types: loader states, NOP encoding, IMEM depth, ALU ops
package cpu_pkg;

  localparam int          IMEM_DEPTH_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte-to-word assembly with a same-cycle word_valid pulse
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] part_q, part_d;

  // The fourth byte is not stored: it completes the word combinationally.
  assign word       = {byte_in, part_q};
  assign word_valid = byte_en && !clear && (cnt_q == 2'd3);

  always_comb begin
    cnt_d  = cnt_q;
    part_d = part_q;
    if (clear) begin
      cnt_d  = 2'd0;
      part_d = '0;
    end else if (byte_en) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    part_d[7:0]   = byte_in;
        2'd1:    part_d[15:8]  = byte_in;
        2'd2:    part_d[23:16] = byte_in;
        default: part_d        = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 2'd0;
      part_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      part_q <= part_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader for the instruction memory feeding the CPU fetch path
module imem_loader
  import cpu_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  num_words,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        busy,
  output logic        done,
  input  logic [31:0] pc,
  output logic [31:0] instruction
);

  localparam int         AW        = $clog2(IMEM_DEPTH);
  localparam logic [5:0] MAX_WORDS = 6'(IMEM_DEPTH);

  loader_state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [5:0]    wcnt_q, wcnt_d;
  logic [5:0]    target_q, target_d;
  logic [31:0]   mem_q [IMEM_DEPTH];
  logic [31:0]   mem_d [IMEM_DEPTH];

  logic [5:0]  clamped;
  logic        byte_en;
  logic        pack_clear;
  logic        word_valid;
  logic [31:0] word;
  logic        unused_pc_bits;

  assign clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;

  // A start in LOAD restarts the session, so no byte is taken on that cycle.
  assign byte_ready  = (state_q == LOAD) && !start;
  assign byte_en     = byte_ready && byte_valid;
  assign busy        = (state_q == LOAD);
  assign done        = (state_q == DONE);
  assign instruction = busy ? NOP_INSTR : mem_q[pc[AW+1:2]];

  assign unused_pc_bits = ^{pc[31:AW+2], pc[1:0]};

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_en    (byte_en),
    .byte_in    (byte_in),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    target_d   = target_q;
    mem_d      = mem_q;
    pack_clear = 1'b0;
    if (start) begin
      pack_clear = 1'b1;
      target_d   = clamped;
      addr_d     = '0;
      wcnt_d     = '0;
      state_d    = (clamped == 6'd0) ? DONE : LOAD;
    end else if (state_q == LOAD && word_valid) begin
      mem_d[addr_q] = word;
      addr_d        = addr_q + 1'b1;
      wcnt_d        = wcnt_q + 6'd1;
      if (wcnt_q + 6'd1 == target_q) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wcnt_q   <= '0;
      target_q <= '0;
      for (int i = 0; i < IMEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wcnt_q   <= wcnt_d;
      target_q <= target_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  num_words;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        done;
  logic [31:0] pc;
  logic [31:0] instruction;

  imem_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_words   (num_words),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .busy        (busy),
    .done        (done),
    .pc          (pc),
    .instruction (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  int          total;
  int          bad;
  logic [7:0]  tx_q[$];
  logic [7:0]  gen_q[$];
  logic [31:0] model_mem [32];
  rd_vec_t     vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = 6'(n);
    tick();
    start = 1'b0;
  endtask

  // mode 0: continuous valid, 1: alternating valid, 2: random valid
  task automatic send_q(input int mode, input bit check_nop, output int acc);
    int budget;
    bit phase;
    budget = 0;
    phase  = 1'b0;
    acc    = 0;
    pc     = 32'h0;
    while (tx_q.size() > 0 && busy && budget < 5000) begin
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = phase;
        default: byte_valid = 1'($urandom);
      endcase
      phase   = ~phase;
      byte_in = tx_q[0];
      #1;
      if (check_nop) begin
        check("busy_during_load", 32'(busy), 32'd1);
        check("nop_while_busy", instruction, 32'h0000_0013);
      end
      if (byte_valid && byte_ready) begin
        void'(tx_q.pop_front());
        acc++;
      end
      tick();
      budget++;
    end
    byte_valid = 1'b0;
    if (budget >= 5000) check("send_budget", 32'(budget), 32'd0);
  endtask

  task automatic rd(input int idx, output logic [31:0] v);
    pc = {$urandom} & ~32'h0000_007C;
    pc = pc | (32'(idx) << 2);
    #1;
    v = instruction;
  endtask

  // Reference: a session writes its first floor(len/4) words, little-endian, from address 0.
  task automatic model_apply(input int nbytes);
    for (int w = 0; w < nbytes / 4; w++) begin
      model_mem[w % 32] = {gen_q[4*w+3], gen_q[4*w+2], gen_q[4*w+1], gen_q[4*w]};
    end
  endtask

  task automatic check_all(input string name);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      rd(i, v);
      check(name, v, model_mem[i]);
    end
  endtask

  initial begin
    logic [31:0] v;
    int acc;
    int n, c, k, n2, c2;
    logic [7:0] prog [12];

    total = 0;
    bad   = 0;
    prog  = '{8'hb3, 8'h03, 8'h53, 8'h00, 8'h33, 8'h85, 8'h84, 8'h40, 8'h93, 8'h06, 8'h16, 8'h00};
    vecs[0] = '{32'h0000_0000, 32'h0053_03b3};
    vecs[1] = '{32'h0000_0004, 32'h4084_8533};
    vecs[2] = '{32'h0000_0008, 32'h0016_0693};
    vecs[3] = '{32'h0000_000C, 32'h0000_0000};
    vecs[4] = '{32'h0000_0007, 32'h4084_8533};
    vecs[5] = '{32'hFFFF_FF80, 32'h0053_03b3};

    reset = 1'b0; start = 1'b0; num_words = '0; byte_in = '0; byte_valid = 1'b0; pc = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_instr", instruction, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    // Continuous 3-word load
    foreach (prog[i]) tx_q.push_back(prog[i]);
    do_start(3);
    send_q(0, 1'b0, acc);
    check("cont_accepted", 32'(acc), 32'd12);
    check("cont_done", 32'(done), 32'd1);
    check("cont_busy", 32'(busy), 32'd0);
    check("cont_ready", 32'(byte_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      pc = vecs[i].addr;
      #1;
      check($sformatf("cont_read%0d", i), instruction, vecs[i].exp);
    end

    // Bytes in DONE are ignored
    tick();
    byte_valid = 1'b1;
    byte_in    = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("done_ready_low", 32'(byte_ready), 32'd0);
      tick();
    end
    byte_valid = 1'b0;
    pc = 32'h0; #1;
    check("done_mem0_kept", instruction, 32'h0053_03b3);
    check("done_still", 32'(done), 32'd1);

    // Reset mid-stream
    tick();
    for (int i = 0; i < 5; i++) tx_q.push_back(prog[i]);
    do_start(3);
    send_q(0, 1'b0, acc);
    reset = 1'b0;
    pc    = 32'h0;
    #2;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ready", 32'(byte_ready), 32'd0);
    check("midrst_instr0", instruction, 32'd0);
    tick();
    reset = 1'b1;
    // Bytes in IDLE are ignored
    byte_valid = 1'b1;
    byte_in    = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("idle_ready_low", 32'(byte_ready), 32'd0);
      check("idle_busy_low", 32'(busy), 32'd0);
      tick();
    end
    byte_valid = 1'b0;
    foreach (model_mem[i]) model_mem[i] = 32'h0;
    check_all("idle_mem_zero");

    // Alternating-valid 3-word load
    tick();
    foreach (prog[i]) tx_q.push_back(prog[i]);
    do_start(3);
    send_q(1, 1'b1, acc);
    check("alt_accepted", 32'(acc), 32'd12);
    check("alt_done", 32'(done), 32'd1);
    for (int i = 0; i < 6; i++) begin
      pc = vecs[i].addr;
      #1;
      check($sformatf("alt_read%0d", i), instruction, vecs[i].exp);
    end

    // Restart mid-load: 6 bytes of a 2-word session, then a 1-word session
    tick();
    for (int i = 0; i < 6; i++) tx_q.push_back(8'h11 + 8'(i));
    do_start(2);
    send_q(0, 1'b0, acc);
    check("rs_busy_before", 32'(busy), 32'd1);
    byte_valid = 1'b1;
    byte_in    = 8'hEE;
    do_start(1);
    byte_valid = 1'b0;
    for (int i = 0; i < 4; i++) tx_q.push_back(prog[i]);
    send_q(0, 1'b0, acc);
    check("rs_accepted", 32'(acc), 32'd4);
    check("rs_done", 32'(done), 32'd1);
    rd(0, v); check("rs_mem0", v, 32'h0053_03b3);
    rd(1, v); check("rs_mem1", v, 32'h4084_8533);
    rd(2, v); check("rs_mem2", v, 32'h0016_0693);

    // Empty program
    tick();
    start = 1'b1; num_words = 6'd0;
    #1;
    check("zero_ready_on_start", 32'(byte_ready), 32'd0);
    tick();
    start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_ready", 32'(byte_ready), 32'd0);
    rd(0, v); check("zero_mem0", v, 32'h0053_03b3);

    // Clamp 40 -> 32 words, 128 bytes
    tick();
    gen_q.delete();
    for (int i = 0; i < 136; i++) gen_q.push_back(8'($urandom));
    tx_q = gen_q;
    do_start(40);
    send_q(0, 1'b0, acc);
    check("clamp_accepted", 32'(acc), 32'd128);
    check("clamp_done", 32'(done), 32'd1);
    check("clamp_ready", 32'(byte_ready), 32'd0);
    model_apply(128);
    check_all("clamp_mem");

    // Random sessions, some restarted partway
    for (int s = 0; s < 6; s++) begin
      tick();
      n = $urandom_range(0, 40);
      c = (n > 32) ? 32 : n;
      if (c > 1 && ($urandom % 2) == 1) begin
        k = $urandom_range(1, 4*c - 1);
        gen_q.delete();
        for (int i = 0; i < k; i++) gen_q.push_back(8'($urandom));
        tx_q = gen_q;
        do_start(n);
        send_q(2, 1'b0, acc);
        check("rnd_partial_acc", 32'(acc), 32'(k));
        model_apply(k);
        byte_valid = 1'b1;
        byte_in    = 8'hEE;
      end
      n2 = $urandom_range(0, 40);
      c2 = (n2 > 32) ? 32 : n2;
      gen_q.delete();
      for (int i = 0; i < 4*c2 + 4; i++) gen_q.push_back(8'($urandom));
      tx_q = gen_q;
      do_start(n2);
      byte_valid = 1'b0;
      send_q(2, 1'b0, acc);
      check("rnd_acc", 32'(acc), 32'(4*c2));
      check("rnd_done", 32'(done), 32'd1);
      model_apply(4*c2);
      check_all("rnd_mem");
      tx_q.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter: IMEM_DEPTH, 32, number of 32-bit instruction words held.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset; state clears while low, independent of clk.
REQ-004 SHALL have port: start  input  1  one-cycle pulse that begins a load session.
REQ-005 SHALL have port: num_words  input  6  words to load, sampled on start; 0 means empty program, values >32 clamp to 32.
REQ-006 SHALL have port: byte_in  input  8  program byte stream, little-endian within each word.
REQ-007 SHALL have port: byte_valid  input  1  byte_in holds a valid byte.
REQ-008 SHALL have port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port: busy  output  1  load session in progress.
REQ-010 SHALL have port: done  output  1  last session completed; held until the next start or reset.
REQ-011 SHALL have port: pc  input  32  CPU fetch address.
REQ-012 SHALL have port: instruction  output  32  combinational fetch data for pc.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-014 SHALL transition IDLE/DONE->LOAD on start with clamped num_words>0, clearing the byte counter (2 bits) and word address (5 bits).
REQ-015 SHALL transition IDLE/DONE->DONE on start with num_words==0, with no memory write.
REQ-016 SHALL assert byte_ready only in LOAD; a byte is accepted on a cycle where byte_valid&&byte_ready is high at the rising edge.
REQ-017 SHALL place accepted byte k (k=0..3) into bits [8k+7:8k] of the word being assembled.
REQ-018 SHALL, on acceptance of byte 3, write the assembled word to mem[word address] on that same edge, increment the word address, and reset the byte counter to 0.
REQ-019 SHALL, when that write is word number num_words (count reaches num_words), go to DONE on the same edge, with byte_ready low from the next cycle.
REQ-020 SHALL restart on start in LOAD: discard the partial word, reload num_words, clear counters, keep previously written words, and take no byte that cycle.
REQ-021 SHALL ignore byte_valid outside LOAD, with no state change.
REQ-022 SHALL drive busy=(state==LOAD) and done=(state==DONE).
REQ-023 SHALL drive instruction=mem[pc[6:2]] combinationally when not busy, and 32'h00000013 (NOP) while busy; pc[1:0] and pc[31:7] are ignored.
REQ-024 SHALL wrap the word address to 0 after address 31 (reachable only with clamped 32).

Reset
REQ-025 SHALL, while reset is low, force state IDLE, clear counters and the partial word, set all mem words to 0, and drive byte_ready=0, busy=0, done=0.
REQ-026 SHALL abort a session when reset is asserted mid-load and leave memory zeroed; the first clk edge after reset deassertion is in IDLE.

Structure
REQ-027 SHALL take loader_state_t (IDLE/LOAD/DONE), the NOP_INSTR constant and IMEM_DEPTH_DEFAULT from the shared cpu package, alongside the ALU op enum.
REQ-028 SHALL put byte-to-word assembly in one sub-module, byte_packer (byte counter, shift-in, word_valid pulse); memory array and FSM stay in imem_loader.
REQ-029 SHALL expose an instruction port that connects directly to the CPU's fetch path in place of the static instruction ROM.

Verification
REQ-030 Reset low mid-stream, then high -> busy=0, done=0, byte_ready=0, instruction at pc=0 is 0.
REQ-031 start with num_words=3, then bytes b3 03 53 00, 33 85 84 40, 93 06 16 00 with continuous valid -> done after the 12th byte; pc=0/4/8 read 005303b3/40848533/00160693; pc=12 reads 0.
REQ-032 Same 3-word load with byte_valid toggling every other cycle -> identical memory, busy high throughout, instruction=00000013 while busy.
REQ-033 start num_words=2, send 6 bytes, start num_words=1, send 4 bytes of 005303b3 -> mem[0]=005303b3, mem[1] unchanged, done=1.
REQ-034 start num_words=0 -> done next cycle, byte_ready never high; start num_words=40 -> exactly 128 bytes accepted, then done.
REQ-035 Bytes driven with byte_valid in IDLE and in DONE -> no memory change, byte_ready stays 0.
